adventure_engine: RTL
=====================

Name: adventure_engine

Overview:
- Parametrised successor to the single-path story FSM.
- Drives the remote-learning text adventure. It accepts player decisions over a valid/ready handshake and tracks a saturating motivation score, one-shot event flags, a mask item and a turn budget.
- Emits a 5-bit story state code that the bench's narration case statement decodes.
- New versus the previous generation: configurable win threshold, motivation step and turn limit; explicit handshake; done/win status; a timeout loss.

Parameters:
- MOTIVATION_GOAL, 5, motivation required for homework to win (1..2^MOT_WIDTH-1).
- MOT_WIDTH, 4, width of the motivation counter; the counter saturates at 2^MOT_WIDTH-1.
- MOTIVATION_STEP, 1, amount added per first-time motivating event.
- MAX_TURNS, 32, accepted-decision budget; 0 disables the timeout.
- TURN_WIDTH, 6, width of the turn counter; must hold MAX_TURNS.

Ports:
- clk, input, 1: rising-edge clock.
- reset, input, 1: asynchronous, active-low reset.
- Decision, input, 2: 00=A, 01=B, 10=C, 11=D.
- decision_valid, input, 1: Decision is presented this cycle.
- decision_ready, output, 1: engine is in a menu state and will accept a decision.
- state, output, 5: story state code.
- motivation, output, MOT_WIDTH: current motivation.
- visited, output, 7: one-shot event flags. Bit 0 bath, 1 kitchen, 2 outside, 3 nap, 4 friends, 5 lecture, 6 videos.
- has_mask, output, 1: mask has been found.
- turns, output, TURN_WIDTH: count of accepted decisions.
- done, output, 1: a terminal state has been reached.
- win, output, 1: terminal state is the success state.

Behaviour:
- Reset (reset=0): immediately, asynchronously, state=21 (IDLE), motivation=0, visited=0, has_mask=0, turns=0, decision_ready=0, done=0, win=0.
- On the first clk edge after reset releases: IDLE goes to 1.
- Menu states: 1 HALL, 2 BEDROOM, 6 DESK, 11 PHONE, 12 LAPTOP.
  - decision_ready=1 only in these states.
  - A decision is accepted at a posedge where decision_valid and decision_ready are both 1.
  - An accepted decision sets the next state that edge and increments turns.
  - If decision_valid=0, the engine holds the menu state.
- HALL (1):
  - A -> 2.
  - B -> 3.
  - C -> 4.
  - D -> 5 if has_mask=1 and outside is not yet visited; 16 if has_mask=1 and outside is already visited; 20 if has_mask=0.
- BEDROOM (2):
  - A -> 6.
  - B -> 7.
  - C -> 8.
  - D -> 1.
- DESK (6):
  - A -> 9 if motivation>=MOTIVATION_GOAL, else 10.
  - B -> 11.
  - C -> 12.
  - D -> 2.
- PHONE (11):
  - A -> 13.
  - B -> 14.
  - C -> 15.
  - D -> 6.
- LAPTOP (12):
  - A -> 17.
  - B -> 18.
  - C -> 19.
  - D -> 6.
- Event states (3, 4, 5, 7, 14, 17, 18):
  - Entering one sets its visited bit and adds MOTIVATION_STEP, saturating at 2^MOT_WIDTH-1.
  - Each lasts exactly one cycle, then returns automatically to its parent menu: 3/4/5 -> 1; 7 -> 2; 14 -> 11; 17/18 -> 12.
  - Selecting an event whose visited bit is already set goes to 16 (ALREADY) instead, with no motivation change. 16 lasts one cycle and returns to the menu that issued the choice.
- Info states (8, 15, 19, 20):
  - One cycle each, repeatable, no motivation change.
  - 8 sets has_mask=1 and returns to 2.
  - 15 returns to 11, 19 returns to 12, 20 returns to 1.
  - Decisions presented during event or info cycles are not accepted and not counted.
- Terminal states: 9 WIN, 10 LOSE_HW, 13 LOSE_DOOM, 22 LOSE_TIMEOUT.
  - Each holds until reset. done=1, decision_ready=0.
  - win=1 only in 9.
  - All outputs are frozen; further decisions are ignored.
- Timeout (MAX_TURNS!=0):
  - If an accepted decision makes turns==MAX_TURNS and its target is non-terminal, the next state is 22 instead.
  - A terminal target on the final turn takes precedence over timeout.
- Turns saturate at 2^TURN_WIDTH-1 when MAX_TURNS=0.
- Reset asserted mid-event or in a terminal state returns immediately to IDLE with all counters cleared.
- Undefined state codes recover to 1 on the next edge.

Test Plan:
- Reset, then release -> state=21 during reset; state=1 one edge after release; motivation=0, turns=0, decision_ready=1.
- HALL C -> state=4 for one cycle, motivation=1, visited=0000010, then state=1. Repeat C -> state=16 for one cycle, then 1; motivation stays 1, turns=2.
- HALL D with no mask -> state=20, then 1. Then A, C -> 8, has_mask=1. Then D (back to HALL), D -> 5, motivation+1, visited[2]=1.
- Earn five distinct events (bath, kitchen, outside, nap, friends), go to DESK, press A -> state=9, done=1, win=1. Subsequent valid decisions leave state=9 and turns unchanged.
- Fresh run, kitchen only (motivation=1), DESK A -> state=10, done=1, win=0. Second run, PHONE A -> state=13.
- MAX_TURNS=4: HALL A, BEDROOM D, HALL A, BEDROOM D -> 4th accept gives state=22, done=1. Pulse reset low mid-run -> state=21 asynchronously, motivation=0, visited=0.

Source files
------------

// File: rtl/adventure_engine.sv
`default_nettype none
// ============================================================================
// Module      : adventure_engine
// Description : Remote-learning text adventure engine. Accepts player
//               decisions over a valid/ready handshake and tracks a
//               saturating motivation score, one-shot event flags, a mask
//               item and a turn budget. Emits a 5-bit story state code.
// Revision    : 1.0 - parametrised successor to the single-path story FSM
// ============================================================================
module adventure_engine #(
   parameter int MOTIVATION_GOAL = 5,
   parameter int MOT_WIDTH       = 4,
   parameter int MOTIVATION_STEP = 1,
   parameter int MAX_TURNS       = 32,
   parameter int TURN_WIDTH      = 6
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [1:0]            Decision,
   input  logic                  decision_valid,
   output logic                  decision_ready,
   output logic [4:0]            state,
   output logic [MOT_WIDTH-1:0]  motivation,
   output logic [6:0]            visited,
   output logic                  has_mask,
   output logic [TURN_WIDTH-1:0] turns,
   output logic                  done,
   output logic                  win
);

   typedef enum logic [4:0] {
      S_HALL      = 5'd1,
      S_BEDROOM   = 5'd2,
      S_BATH      = 5'd3,
      S_KITCHEN   = 5'd4,
      S_OUTSIDE   = 5'd5,
      S_DESK      = 5'd6,
      S_NAP       = 5'd7,
      S_MASK      = 5'd8,
      S_WIN       = 5'd9,
      S_LOSE_HW   = 5'd10,
      S_PHONE     = 5'd11,
      S_LAPTOP    = 5'd12,
      S_LOSE_DOOM = 5'd13,
      S_FRIENDS   = 5'd14,
      S_NEWS      = 5'd15,
      S_ALREADY   = 5'd16,
      S_LECTURE   = 5'd17,
      S_VIDEOS    = 5'd18,
      S_SOCIAL    = 5'd19,
      S_NOMASK    = 5'd20,
      S_IDLE      = 5'd21,
      S_TIMEOUT   = 5'd22
   } state_t;

   localparam logic [MOT_WIDTH:0]    MOT_STEP_C = (MOT_WIDTH+1)'(MOTIVATION_STEP);
   localparam logic [MOT_WIDTH-1:0]  MOT_MAX_C  = {MOT_WIDTH{1'b1}};
   localparam logic [MOT_WIDTH-1:0]  MOT_GOAL_C = MOT_WIDTH'(MOTIVATION_GOAL);
   localparam logic [TURN_WIDTH-1:0] TURN_MAX_C = {TURN_WIDTH{1'b1}};
   localparam logic [TURN_WIDTH-1:0] TURN_LIM_C = TURN_WIDTH'(MAX_TURNS);
   localparam logic                  TIMEOUT_EN = (MAX_TURNS != 0);

   state_t                  cur_state, next_state;
   state_t                  ret_state, next_ret;
   state_t                  menu_target;
   logic [MOT_WIDTH-1:0]    mot_q, next_mot;
   logic [6:0]              vis_q, next_vis;
   logic                    mask_q, next_mask;
   logic [TURN_WIDTH-1:0]   turns_q, next_turns;
   logic [MOT_WIDTH:0]      mot_sum;
   logic [MOT_WIDTH-1:0]    mot_sat;
   logic [TURN_WIDTH-1:0]   turns_inc;
   logic                    timeout_hit;
   logic                    is_menu, is_terminal;

   // One-hot visited flag owned by an event state; zero for non-event codes.
   function automatic logic [6:0] event_flag(input state_t s);
      logic [6:0] f;
      f = 7'd0;
      case (s)
         S_BATH:    f = 7'b0000001;
         S_KITCHEN: f = 7'b0000010;
         S_OUTSIDE: f = 7'b0000100;
         S_NAP:     f = 7'b0001000;
         S_FRIENDS: f = 7'b0010000;
         S_LECTURE: f = 7'b0100000;
         S_VIDEOS:  f = 7'b1000000;
         default:   f = 7'd0;
      endcase
      return f;
   endfunction

   function automatic logic target_terminal(input state_t s);
      return (s == S_WIN) || (s == S_LOSE_HW) || (s == S_LOSE_DOOM) || (s == S_TIMEOUT);
   endfunction

   // Saturating arithmetic shared by the next-state logic.
   always_comb begin
      mot_sum     = {1'b0, mot_q} + MOT_STEP_C;
      mot_sat     = (mot_sum > {1'b0, MOT_MAX_C}) ? MOT_MAX_C : mot_sum[MOT_WIDTH-1:0];
      turns_inc   = (turns_q == TURN_MAX_C) ? turns_q : turns_q + 1'b1;
      timeout_hit = TIMEOUT_EN && (turns_inc == TURN_LIM_C);
   end

   // Menu decoding: raw destination of the presented decision.
   always_comb begin
      menu_target = S_HALL;
      case (cur_state)
         S_HALL: begin
            case (Decision)
               2'b00:   menu_target = S_BEDROOM;
               2'b01:   menu_target = S_BATH;
               2'b10:   menu_target = S_KITCHEN;
               default: menu_target = mask_q ? S_OUTSIDE : S_NOMASK;
            endcase
         end
         S_BEDROOM: begin
            case (Decision)
               2'b00:   menu_target = S_DESK;
               2'b01:   menu_target = S_NAP;
               2'b10:   menu_target = S_MASK;
               default: menu_target = S_HALL;
            endcase
         end
         S_DESK: begin
            case (Decision)
               2'b00:   menu_target = (mot_q >= MOT_GOAL_C) ? S_WIN : S_LOSE_HW;
               2'b01:   menu_target = S_PHONE;
               2'b10:   menu_target = S_LAPTOP;
               default: menu_target = S_BEDROOM;
            endcase
         end
         S_PHONE: begin
            case (Decision)
               2'b00:   menu_target = S_LOSE_DOOM;
               2'b01:   menu_target = S_FRIENDS;
               2'b10:   menu_target = S_NEWS;
               default: menu_target = S_DESK;
            endcase
         end
         S_LAPTOP: begin
            case (Decision)
               2'b00:   menu_target = S_LECTURE;
               2'b01:   menu_target = S_VIDEOS;
               2'b10:   menu_target = S_SOCIAL;
               default: menu_target = S_DESK;
            endcase
         end
         default: menu_target = S_HALL;
      endcase
   end

   // Next-state and bookkeeping updates; side effects apply on entry to a state.
   always_comb begin
      state_t resolved;
      logic [6:0] flag;
      next_state = cur_state;
      next_ret   = ret_state;
      next_mot   = mot_q;
      next_vis   = vis_q;
      next_mask  = mask_q;
      next_turns = turns_q;
      resolved   = menu_target;
      flag       = event_flag(menu_target);
      case (cur_state)
         S_IDLE: next_state = S_HALL;
         S_HALL, S_BEDROOM, S_DESK, S_PHONE, S_LAPTOP: begin
            if (decision_valid) begin
               next_turns = turns_inc;
               // A repeated one-shot event detours through ALREADY instead.
               if ((flag & vis_q) != 7'd0) begin
                  resolved = S_ALREADY;
                  flag     = 7'd0;
                  next_ret = cur_state;
               end
               if (timeout_hit && !target_terminal(resolved)) begin
                  next_state = S_TIMEOUT;
               end else begin
                  next_state = resolved;
                  if (flag != 7'd0) begin
                     next_vis = vis_q | flag;
                     next_mot = mot_sat;
                  end
                  if (resolved == S_MASK) next_mask = 1'b1;
               end
            end
         end
         S_BATH, S_KITCHEN, S_OUTSIDE, S_NOMASK:  next_state = S_HALL;
         S_NAP, S_MASK:                           next_state = S_BEDROOM;
         S_FRIENDS, S_NEWS:                       next_state = S_PHONE;
         S_LECTURE, S_VIDEOS, S_SOCIAL:           next_state = S_LAPTOP;
         S_ALREADY:                               next_state = ret_state;
         S_WIN, S_LOSE_HW, S_LOSE_DOOM, S_TIMEOUT: next_state = cur_state;
         default:                                 next_state = S_HALL;
      endcase
   end

   // State and score registers with asynchronous active-low clear.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cur_state <= S_IDLE;
         ret_state <= S_HALL;
         mot_q     <= '0;
         vis_q     <= '0;
         mask_q    <= 1'b0;
         turns_q   <= '0;
      end else begin
         cur_state <= next_state;
         ret_state <= next_ret;
         mot_q     <= next_mot;
         vis_q     <= next_vis;
         mask_q    <= next_mask;
         turns_q   <= next_turns;
      end
   end

   // Status outputs decoded from the current state.
   always_comb begin
      is_menu     = (cur_state == S_HALL) || (cur_state == S_BEDROOM) ||
                    (cur_state == S_DESK) || (cur_state == S_PHONE) ||
                    (cur_state == S_LAPTOP);
      is_terminal = target_terminal(cur_state);
      decision_ready = is_menu;
      done           = is_terminal;
      win            = (cur_state == S_WIN);
      state          = cur_state;
      motivation     = mot_q;
      visited        = vis_q;
      has_mask       = mask_q;
      turns          = turns_q;
   end

endmodule
`default_nettype wire
